// File: rtl/mac_pkg.sv
// Shared widths, operand/accumulator types and saturation limits for the MAC neuron core.
// No logic; constants only.
// Consumers: mac_core, mac_narrow.
package mac_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;

  typedef logic signed [DATA_W_DEF-1:0] data_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  localparam data_t SAT_MAX = data_t'((2 ** (DATA_W_DEF - 1)) - 1);
  localparam data_t SAT_MIN = data_t'(-(2 ** (DATA_W_DEF - 1)));

endpackage

// File: rtl/mac_narrow.sv
// Scale accumulator by FRAC_BITS and narrow to DATA_W (saturate if MAC_CORE_SAT_EN, else wrap).
// Latency: combinational.
// Backpressure: none.
module mac_narrow
  import mac_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = 0
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] res
);

`ifdef MAC_CORE_SAT_EN
  localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

  logic [ACC_W-1:0]        shifted;
  logic [ACC_W-DATA_W:0]   upper;
  logic                    fits;

  assign shifted = $signed(acc) >>> FRAC_BITS;
  // Value fits in DATA_W when every bit from the target sign bit upward agrees.
  assign upper   = shifted[ACC_W-1:DATA_W-1];
  assign fits    = (&upper) | ~(|upper);

  always_comb begin
    res = shifted[DATA_W-1:0];
    if (!fits) begin
      res = shifted[ACC_W-1] ? MINV : MAXV;
    end
  end
`else
  assign res = DATA_W'($signed(acc) >>> FRAC_BITS);
`endif

endmodule

// File: rtl/mac_core.sv
// Signed multiply-accumulate neuron core; output narrowing selected by MAC_CORE_SAT_EN.
// Latency: one clock operand-to-acc; out is combinational from acc and oe.
// Backpressure: none, an operand pair is consumed every clock with oe=0.
module mac_core
  import mac_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] in,
  input  logic              oe,
  input  logic              forget,
  output logic [DATA_W-1:0] out
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc;
  logic [DATA_W-1:0]   narrowed;

  // Sign-extending both operands makes the low 2*DATA_W bits of an unsigned
  // multiply equal to the signed product.
  assign prod     = {{DATA_W{weight[DATA_W-1]}}, weight} * {{DATA_W{in[DATA_W-1]}}, in};
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else if (forget) begin
      acc <= '0;
    end else if (!oe) begin
      acc <= acc + prod_ext;
    end
  end

  mac_narrow #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_narrow (
    .acc (acc),
    .res (narrowed)
  );

  assign out = oe ? narrowed : '0;

endmodule

// File: tb/tb_mac_core.sv
// Scoreboard bench for mac_core: directed cases then random traffic against an integer model.
module tb_mac_core;
  import mac_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 20;
  localparam int FRAC = 0;

  logic          clk;
  logic          reset;
  logic [DW-1:0] weight;
  logic [DW-1:0] in;
  logic          oe;
  logic          forget;
  logic [DW-1:0] out;

  typedef struct {
    int    exp;
    string tag;
  } exp_t;

  exp_t   sbq[$];
  exp_t   cur;
  int     checks = 0;
  int     errors = 0;
  longint macc   = 0;

  mac_core #(.DATA_W(DW), .ACC_W(AW), .FRAC_BITS(FRAC)) dut (
    .clk    (clk),
    .reset  (reset),
    .weight (weight),
    .in     (in),
    .oe     (oe),
    .forget (forget),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) <<< w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic int model_out(input longint a, input bit o);
    longint v;
    if (!o) return 0;
    v = a >>> FRAC;
`ifdef MAC_CORE_SAT_EN
    if (v > longint'(SAT_MAX)) return int'(SAT_MAX);
    if (v < longint'(SAT_MIN)) return int'(SAT_MIN);
    return int'(v);
`else
    return int'(wrapw(v, DW));
`endif
  endfunction

  // Drive one clock's worth of inputs; expectation reflects acc before this edge.
  task automatic step(input bit r, input bit f, input bit o, input int w, input int x,
                      input string tag);
    exp_t e;
    reset  = r;
    forget = f;
    oe     = o;
    weight = DW'(w);
    in     = DW'(x);
    e.exp  = model_out(macc, o);
    e.tag  = tag;
    sbq.push_back(e);
    if (!r)      macc = 0;
    else if (f)  macc = 0;
    else if (!o) macc = wrapw(macc + longint'(w) * longint'(x), AW);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      checks++;
      if (int'($signed(out)) != cur.exp) begin
        errors++;
        $display("FAIL %s: out=%0d expected %0d", cur.tag, $signed(out), cur.exp);
      end
    end
  end

  initial begin
    reset = 1'b0; forget = 1'b0; oe = 1'b0; weight = '0; in = '0;
    @(posedge clk);
    #1;

    // Sum and hold
    step(0, 0, 0, 0, 0, "reset_oe0");
    step(0, 0, 1, 5, 5, "reset_oe1");
    repeat (3) step(1, 0, 0, 2, 2, "sum_acc");
    repeat (3) step(1, 0, 1, 2, 2, "sum_hold");
    // Output gating
    step(1, 0, 0, 0, 7, "gate_low");
    step(1, 0, 1, 0, 7, "gate_high");

    // Signed sum
    step(0, 0, 0, 0, 0, "signed_rst");
    step(1, 0, 0, 2, 2, "signed_a");
    step(1, 0, 0, -2, 2, "signed_b");
    step(1, 0, 0, -2, 2, "signed_c");
    step(1, 0, 1, 9, 9, "signed_out");

    // Narrowing beyond the output range
    step(0, 0, 0, 0, 0, "sat_rst");
    repeat (2) step(1, 0, 0, 127, 127, "sat_pos_acc");
    step(1, 0, 1, 0, 0, "sat_pos_out");
    step(0, 0, 0, 0, 0, "sat_rst2");
    repeat (2) step(1, 0, 0, -128, 127, "sat_neg_acc");
    step(1, 0, 1, 0, 0, "sat_neg_out");

    // Forget vs reset
    step(0, 0, 0, 0, 0, "fg_rst");
    repeat (2) step(1, 0, 0, 3, 3, "fg_acc");
    step(1, 1, 0, 3, 3, "fg_forget");
    step(1, 0, 0, 1, 1, "fg_one");
    step(1, 0, 1, 0, 0, "fg_out");
    repeat (2) step(1, 0, 0, 4, 4, "mid_acc");
    step(0, 0, 0, 4, 4, "mid_reset");
    step(1, 0, 1, 0, 0, "mid_out");

    // Priority
    repeat (2) step(1, 0, 0, 6, 6, "pri_acc");
    step(0, 1, 1, 6, 6, "pri_rst_fg");
    step(1, 0, 1, 0, 0, "pri_rst_out");
    repeat (2) step(1, 0, 0, 6, 6, "pri_acc2");
    step(1, 1, 1, 6, 6, "pri_fg_oe");
    step(1, 0, 1, 6, 6, "pri_fg_out");

    // Accumulator wrap at ACC_W
    step(0, 0, 0, 0, 0, "wrap_rst");
    for (int i = 0; i < 40; i++) step(1, 0, (i % 8) == 7, -128, -128, "wrap_run");
    step(1, 0, 1, 0, 0, "wrap_out");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, "random");
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
